fc_param_loader: RTL

// - Write side of the FC weight/bias interface: receives a serial stream of PX_SIZE-bit words

---
 rtl/fc_param_loader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fc_param_loader.sv
// fc_param_loader: fills the packed FC weight/bias registers from a valid/ready word stream.
// Define FC_PARAM_LOADER_CHECKSUM_EN to require a trailing checksum word and expose chk_err.
module fc_param_loader #(
  parameter int unsigned INPUT_SIZE      = 5,
  parameter int unsigned INPUT_CHANNELS  = 3,
  parameter int unsigned OUTPUT_CHANNELS = 3,
  parameter int unsigned PX_SIZE         = 8,
  localparam int unsigned FLAT = INPUT_SIZE * INPUT_SIZE * INPUT_CHANNELS,
  localparam int unsigned NW   = OUTPUT_CHANNELS * FLAT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [PX_SIZE-1:0]                 in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [NW*PX_SIZE-1:0]              weights,
  output logic [OUTPUT_CHANNELS*PX_SIZE-1:0] biases,
  output logic                               params_valid,
  output logic                               busy,
  output logic                               done
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
  ,
  output logic                               chk_err
`endif
);

  localparam int unsigned CNT_W = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadB,
    StDone
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
    ,
    StLoadC
`endif
  } state_e;

  state_e                                    r_state;
  logic [CNT_W-1:0]                          r_cnt;
  logic [NW-1:0][PX_SIZE-1:0]                r_weights;
  logic [OUTPUT_CHANNELS-1:0][PX_SIZE-1:0]   r_biases;
  logic                                      r_in_ready;
  logic                                      r_busy;
  logic                                      r_done;
  logic                                      r_params_valid;
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
  logic [PX_SIZE-1:0]                        r_sum;
  logic                                      r_chk_err;
`endif

  logic w_xfer;
  logic w_last_w;
  logic w_last_b;

  assign w_xfer   = in_valid & r_in_ready;
  assign w_last_w = (r_cnt == CNT_W'(NW - 1));
  assign w_last_b = (r_cnt == CNT_W'(OUTPUT_CHANNELS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_weights      <= '0;
      r_biases       <= '0;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_params_valid <= 1'b0;
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
      r_sum          <= '0;
      r_chk_err      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
      r_chk_err <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          // abort outranks start even while idle
          if (start && !abort) begin
            r_state        <= StLoadW;
            r_cnt          <= '0;
            r_params_valid <= 1'b0;
            r_in_ready     <= 1'b1;
            r_busy         <= 1'b1;
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
            r_sum          <= '0;
`endif
          end
        end
        StLoadW: begin
          if (abort) begin
            r_state    <= StIdle;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_xfer) begin
            for (int unsigned i = 0; i < NW; i++) begin
              if (r_cnt == CNT_W'(i)) r_weights[i] <= in_data;
            end
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
            r_sum <= r_sum + in_data;
`endif
            if (w_last_w) begin
              r_state <= StLoadB;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StLoadB: begin
          if (abort) begin
            r_state    <= StIdle;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_xfer) begin
            for (int unsigned i = 0; i < OUTPUT_CHANNELS; i++) begin
              if (r_cnt == CNT_W'(i)) r_biases[i] <= in_data;
            end
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
            r_sum <= r_sum + in_data;
`endif
            if (w_last_b) begin
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
              r_state        <= StLoadC;
`else
              r_state        <= StDone;
              r_in_ready     <= 1'b0;
              r_busy         <= 1'b0;
              r_done         <= 1'b1;
              r_params_valid <= 1'b1;
`endif
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
        StLoadC: begin
          if (abort) begin
            r_state    <= StIdle;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_xfer) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (in_data == r_sum) begin
              r_state        <= StDone;
              r_done         <= 1'b1;
              r_params_valid <= 1'b1;
            end else begin
              r_state   <= StIdle;
              r_chk_err <= 1'b1;
            end
          end
        end
`endif
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign weights      = r_weights;
  assign biases       = r_biases;
  assign params_valid = r_params_valid;
  assign busy         = r_busy;
  assign done         = r_done;
`ifdef FC_PARAM_LOADER_CHECKSUM_EN
  assign chk_err      = r_chk_err;
`endif

endmodule
